// File: rtl/prim_prio_claim_pkg.sv
// Shared types and constants for the priority claim stage.
//  claim_state_e   : offer FSM state (idle / offering a winner)
//  ClaimIdxDefault : value held in the offered-index register out of reset
package prim_prio_claim_pkg;

   typedef enum logic {
      ClaimIdle  = 1'b0,
      ClaimOffer = 1'b1
   } claim_state_e;

   localparam int unsigned ClaimIdxDefault = 32'd0;

endpackage

// File: rtl/prim_prio_claim_if.sv
// Bus bundle for prim_prio_claim.
//  slave  : the claim stage (consumes requests/handshakes, drives offer/status)
//  master : the environment (drives requests, priorities, ready, completion)
// Signals:
//  req_i, prio_i, threshold_i        request capture and eligibility
//  claim_valid_o/ready_i/idx_o/prio_o  downstream offer handshake
//  complete_valid_i, complete_idx_i   consumer finished a source
//  pending_o, in_service_o            per-source status vectors
interface prim_prio_claim_if #(
   parameter int NumSrc = 32,
   parameter int Width  = 8
);
   localparam int SrcWidth = $clog2(NumSrc);

   logic [NumSrc-1:0]       req_i;
   logic [NumSrc*Width-1:0] prio_i;
   logic [Width-1:0]        threshold_i;
   logic                    claim_valid_o;
   logic                    claim_ready_i;
   logic [SrcWidth-1:0]     claim_idx_o;
   logic [Width-1:0]        claim_prio_o;
   logic                    complete_valid_i;
   logic [SrcWidth-1:0]     complete_idx_i;
   logic [NumSrc-1:0]       pending_o;
   logic [NumSrc-1:0]       in_service_o;

   modport slave (
      input  req_i, prio_i, threshold_i, claim_ready_i,
             complete_valid_i, complete_idx_i,
      output claim_valid_o, claim_idx_o, claim_prio_o,
             pending_o, in_service_o
   );

   modport master (
      output req_i, prio_i, threshold_i, claim_ready_i,
             complete_valid_i, complete_idx_i,
      input  claim_valid_o, claim_idx_o, claim_prio_o,
             pending_o, in_service_o
   );

endinterface

// File: rtl/prim_max_tree.sv
// Combinational binary max tree: picks the valid input with the largest
// unsigned value; on equal values the lower index wins.
// Ports:
//  valid_i     : per-input valid
//  values_i    : per-input value, packed input 0 in the LSBs
//  max_valid_o : at least one input valid
//  max_idx_o   : index of the winner
//  max_value_o : value of the winner
module prim_max_tree #(
   parameter  int NumSrc   = 32,
   parameter  int Width    = 8,
   localparam int SrcWidth = $clog2(NumSrc)
) (
   input  logic [NumSrc-1:0]       valid_i,
   input  logic [NumSrc*Width-1:0] values_i,
   output logic                    max_valid_o,
   output logic [SrcWidth-1:0]     max_idx_o,
   output logic [Width-1:0]        max_value_o
);

   localparam int NumLevels = $clog2(NumSrc);
   localparam int NumLeaves = 2 ** NumLevels;
   localparam int NumNodes  = 2 * NumLeaves - 1;
   localparam int LeafBase  = NumLeaves - 1;

   // Heap-ordered nodes: node 0 is the root, children of n are 2n+1 / 2n+2.
   logic                        vld_s [NumNodes];
   logic [SrcWidth-1:0]         idx_s [NumNodes];
   logic [Width-1:0]            val_s [NumNodes];
   logic [NumLeaves-1:0]        valid_pad_s;
   logic [NumLeaves*Width-1:0]  values_pad_s;

   // Leaf fill followed by bottom-up reduction; padded leaves stay invalid.
   always_comb begin
      valid_pad_s                    = '0;
      valid_pad_s[NumSrc-1:0]        = valid_i;
      values_pad_s                   = '0;
      values_pad_s[NumSrc*Width-1:0] = values_i;
      for (int n = 0; n < NumNodes; n++) begin
         vld_s[n] = 1'b0;
         idx_s[n] = '0;
         val_s[n] = '0;
      end
      for (int k = 0; k < NumLeaves; k++) begin
         vld_s[LeafBase+k] = valid_pad_s[k];
         idx_s[LeafBase+k] = SrcWidth'(k);
         val_s[LeafBase+k] = values_pad_s[k*Width +: Width];
      end
      // Left child always covers lower indices, so the right one wins only
      // when strictly larger (or the left one is invalid).
      for (int n = LeafBase - 1; n >= 0; n--) begin
         if (vld_s[2*n+2] && (!vld_s[2*n+1] || (val_s[2*n+2] > val_s[2*n+1]))) begin
            vld_s[n] = 1'b1;
            idx_s[n] = idx_s[2*n+2];
            val_s[n] = val_s[2*n+2];
         end else begin
            vld_s[n] = vld_s[2*n+1];
            idx_s[n] = idx_s[2*n+1];
            val_s[n] = val_s[2*n+1];
         end
      end
   end

   assign max_valid_o = vld_s[0];
   assign max_idx_o   = idx_s[0];
   assign max_value_o = val_s[0];

endmodule

// File: rtl/prim_prio_claim_chk.sv
// Protocol and state-consistency checks for prim_prio_claim.
// Ports mirror the claim stage's internal registers.
module prim_prio_claim_chk #(
   parameter  int NumSrc   = 32,
   parameter  int Width    = 8,
   localparam int SrcWidth = $clog2(NumSrc)
) (
   input logic                clk_i,
   input logic                rst_ni,
   input logic                claim_valid_i,
   input logic                claim_ready_i,
   input logic [SrcWidth-1:0] claim_idx_i,
   input logic [Width-1:0]    claim_prio_i,
   input logic [NumSrc-1:0]   pending_i,
   input logic [NumSrc-1:0]   in_service_i
);

   // An offer is held, unchanged, until the consumer accepts it.
   offer_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (claim_valid_i && !claim_ready_i) |=>
      (claim_valid_i && $stable(claim_idx_i) && $stable(claim_prio_i)));

   // The offered source is still waiting and not yet being serviced.
   offer_pending_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      claim_valid_i |-> (pending_i[claim_idx_i] && !in_service_i[claim_idx_i]));

   // A source is never pending and in service at once.
   state_excl_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      ((pending_i & in_service_i) == '0));

endmodule

// File: rtl/prim_prio_claim.sv
// Request-capture and claim stage around a max tree.
// Captures request pulses into per-source pending bits, picks the highest
// priority pending source above threshold, offers it downstream with a
// valid/ready handshake and masks it (in service) until completion.
// Ports:
//  clk_i  : clock
//  rst_ni : asynchronous active-low reset
//  bus    : prim_prio_claim_if.slave (requests, offer handshake, completion, status)
module prim_prio_claim
   import prim_prio_claim_pkg::*;
#(
   parameter int NumSrc = 32,
   parameter int Width  = 8
) (
   input logic              clk_i,
   input logic              rst_ni,
   prim_prio_claim_if.slave bus
);

   localparam int                SrcWidth  = $clog2(NumSrc);
   localparam logic [SrcWidth:0] NumSrcW   = (SrcWidth + 1)'(NumSrc);
   localparam logic [NumSrc-1:0] OneHotLsb = {{(NumSrc - 1){1'b0}}, 1'b1};

   logic [NumSrc-1:0]   pending_r;
   logic [NumSrc-1:0]   in_service_r;
   logic [NumSrc-1:0]   pending_nxt_s;
   logic [NumSrc-1:0]   in_service_nxt_s;
   logic [NumSrc-1:0]   tree_valid_s;
   logic [NumSrc-1:0]   req_set_s;
   logic [NumSrc-1:0]   hs_clr_s;
   logic [NumSrc-1:0]   comp_clr_s;
   logic                handshake_s;
   logic                comp_ok_s;
   claim_state_e        state_r;
   logic                claim_valid_r;
   logic [SrcWidth-1:0] claim_idx_r;
   logic [Width-1:0]    claim_prio_r;
   logic                max_valid_s;
   logic [SrcWidth-1:0] max_idx_s;
   logic [Width-1:0]    max_value_s;

   // Eligibility: pending and strictly above threshold (unsigned).
   always_comb begin
      tree_valid_s = '0;
      for (int i = 0; i < NumSrc; i++) begin
         tree_valid_s[i] = pending_r[i] && (bus.prio_i[i*Width +: Width] > bus.threshold_i);
      end
   end

   prim_max_tree #(
      .NumSrc (NumSrc),
      .Width  (Width)
   ) u_max_tree (
      .valid_i     (tree_valid_s),
      .values_i    (bus.prio_i),
      .max_valid_o (max_valid_s),
      .max_idx_o   (max_idx_s),
      .max_value_o (max_value_s)
   );

   // Next-state of the pending / in-service vectors. Requests are gated by
   // the current in-service bit, so a request in the completion cycle is lost.
   always_comb begin
      handshake_s      = claim_valid_r && bus.claim_ready_i;
      comp_ok_s        = bus.complete_valid_i && ({1'b0, bus.complete_idx_i} < NumSrcW);
      hs_clr_s         = handshake_s ? (OneHotLsb << claim_idx_r) : '0;
      comp_clr_s       = comp_ok_s ? (OneHotLsb << bus.complete_idx_i) : '0;
      req_set_s        = bus.req_i & ~pending_r & ~in_service_r;
      pending_nxt_s    = (pending_r | req_set_s) & ~hs_clr_s;
      in_service_nxt_s = (in_service_r & ~comp_clr_s) | hs_clr_s;
   end

   // Per-source state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_r    <= '0;
         in_service_r <= '0;
      end else begin
         pending_r    <= pending_nxt_s;
         in_service_r <= in_service_nxt_s;
      end
   end

   // Offer FSM: latch the tree winner when idle, hold it until accepted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r       <= ClaimIdle;
         claim_valid_r <= 1'b0;
         claim_idx_r   <= SrcWidth'(ClaimIdxDefault);
         claim_prio_r  <= '0;
      end else begin
         case (state_r)
            ClaimIdle: begin
               if (max_valid_s) begin
                  state_r       <= ClaimOffer;
                  claim_valid_r <= 1'b1;
                  claim_idx_r   <= max_idx_s;
                  claim_prio_r  <= max_value_s;
               end else begin
                  state_r       <= ClaimIdle;
                  claim_valid_r <= 1'b0;
               end
            end
            ClaimOffer: begin
               if (bus.claim_ready_i) begin
                  state_r       <= ClaimIdle;
                  claim_valid_r <= 1'b0;
               end else begin
                  state_r       <= ClaimOffer;
                  claim_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r       <= ClaimIdle;
               claim_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.claim_valid_o = claim_valid_r;
   assign bus.claim_idx_o   = claim_idx_r;
   assign bus.claim_prio_o  = claim_prio_r;
   assign bus.pending_o     = pending_r;
   assign bus.in_service_o  = in_service_r;

   prim_prio_claim_chk #(
      .NumSrc (NumSrc),
      .Width  (Width)
   ) u_chk (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .claim_valid_i (claim_valid_r),
      .claim_ready_i (bus.claim_ready_i),
      .claim_idx_i   (claim_idx_r),
      .claim_prio_i  (claim_prio_r),
      .pending_i     (pending_r),
      .in_service_i  (in_service_r)
   );

endmodule

// File: tb/tb_prim_prio_claim.sv
// Directed self-checking bench for prim_prio_claim (32-source main instance
// plus a 5-source instance for the non-power-of-two corner cases).
module tb_prim_prio_claim;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   prim_prio_claim_if #(.NumSrc(32), .Width(8)) ifc ();
   prim_prio_claim_if #(.NumSrc(5),  .Width(8)) ifc5 ();

   prim_prio_claim #(.NumSrc(32), .Width(8)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (ifc.slave)
   );

   prim_prio_claim #(.NumSrc(5), .Width(8)) dut5 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (ifc5.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_prio(input int idx, input logic [7:0] p);
      ifc.prio_i[idx*8 +: 8] = p;
   endtask

   function automatic logic [13:0] offer();
      return {ifc.claim_valid_o, ifc.claim_idx_o, ifc.claim_prio_o};
   endfunction

   function automatic logic [11:0] offer5();
      return {ifc5.claim_valid_o, ifc5.claim_idx_o, ifc5.claim_prio_o};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      ifc.req_i = '0; ifc.prio_i = '0; ifc.threshold_i = '0;
      ifc.claim_ready_i = 1'b0; ifc.complete_valid_i = 1'b0; ifc.complete_idx_i = '0;
      ifc5.req_i = '0; ifc5.prio_i = '0; ifc5.threshold_i = '0;
      ifc5.claim_ready_i = 1'b0; ifc5.complete_valid_i = 1'b0; ifc5.complete_idx_i = '0;
      repeat (3) step();
      vectors++;
      if (offer() !== 14'h0) begin miscompares++; $display("FAIL reset_offer: got %h want %h", offer(), 14'h0); end
      vectors++;
      if ({ifc.pending_o, ifc.in_service_o} !== 64'h0) begin miscompares++; $display("FAIL reset_status: got %h want %h", {ifc.pending_o, ifc.in_service_o}, 64'h0); end
      vectors++;
      if (offer5() !== 12'h0) begin miscompares++; $display("FAIL reset_offer5: got %h want %h", offer5(), 12'h0); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      set_prio(5, 8'd3);
      ifc.threshold_i = 8'd0;
      ifc.req_i = 32'h0000_0020;
      step();
      ifc.req_i = '0;
      vectors++;
      if ({ifc.pending_o, offer()} !== {32'h0000_0020, 14'h0}) begin miscompares++; $display("FAIL single_pending: got %h want %h", {ifc.pending_o, offer()}, {32'h0000_0020, 14'h0}); end
      step();
      vectors++;
      if (offer() !== {1'b1, 5'd5, 8'd3}) begin miscompares++; $display("FAIL single_offer: got %h want %h", offer(), {1'b1, 5'd5, 8'd3}); end
      ifc.claim_ready_i = 1'b1;
      step();
      ifc.claim_ready_i = 1'b0;
      vectors++;
      if ({ifc.claim_valid_o, ifc.pending_o, ifc.in_service_o} !== {1'b0, 32'h0, 32'h0000_0020}) begin miscompares++; $display("FAIL single_claimed: got %h want %h", {ifc.claim_valid_o, ifc.pending_o, ifc.in_service_o}, {1'b0, 32'h0, 32'h0000_0020}); end
      ifc.complete_valid_i = 1'b1; ifc.complete_idx_i = 5'd5;
      step();
      ifc.complete_valid_i = 1'b0;
      vectors++;
      if (ifc.in_service_o !== 32'h0) begin miscompares++; $display("FAIL single_complete: got %h want %h", ifc.in_service_o, 32'h0); end
   endtask

   task automatic test_priority();
      set_prio(2, 8'd7); set_prio(9, 8'd12); set_prio(20, 8'd12);
      ifc.req_i = 32'h0010_0204;
      step();
      ifc.req_i = '0;
      step();
      vectors++;
      if (offer() !== {1'b1, 5'd9, 8'd12}) begin miscompares++; $display("FAIL prio_first: got %h want %h", offer(), {1'b1, 5'd9, 8'd12}); end
      ifc.claim_ready_i = 1'b1;
      step();
      vectors++;
      if ({ifc.claim_valid_o, ifc.pending_o, ifc.in_service_o} !== {1'b0, 32'h0010_0004, 32'h0000_0200}) begin miscompares++; $display("FAIL prio_after_first: got %h want %h", {ifc.claim_valid_o, ifc.pending_o, ifc.in_service_o}, {1'b0, 32'h0010_0004, 32'h0000_0200}); end
      step();
      vectors++;
      if (offer() !== {1'b1, 5'd20, 8'd12}) begin miscompares++; $display("FAIL prio_second: got %h want %h", offer(), {1'b1, 5'd20, 8'd12}); end
      // complete 9 in the same cycle as the handshake of 20
      ifc.complete_valid_i = 1'b1; ifc.complete_idx_i = 5'd9;
      step();
      ifc.complete_valid_i = 1'b0;
      vectors++;
      if ({ifc.claim_valid_o, ifc.pending_o, ifc.in_service_o} !== {1'b0, 32'h0000_0004, 32'h0010_0000}) begin miscompares++; $display("FAIL prio_hs_and_complete: got %h want %h", {ifc.claim_valid_o, ifc.pending_o, ifc.in_service_o}, {1'b0, 32'h0000_0004, 32'h0010_0000}); end
      step();
      vectors++;
      if (offer() !== {1'b1, 5'd2, 8'd7}) begin miscompares++; $display("FAIL prio_third: got %h want %h", offer(), {1'b1, 5'd2, 8'd7}); end
      step();
      ifc.claim_ready_i = 1'b0;
      vectors++;
      if ({ifc.pending_o, ifc.in_service_o} !== {32'h0, 32'h0010_0004}) begin miscompares++; $display("FAIL prio_all_claimed: got %h want %h", {ifc.pending_o, ifc.in_service_o}, {32'h0, 32'h0010_0004}); end
      ifc.complete_valid_i = 1'b1; ifc.complete_idx_i = 5'd20;
      step();
      ifc.complete_idx_i = 5'd2;
      step();
      ifc.complete_valid_i = 1'b0;
      vectors++;
      if (ifc.in_service_o !== 32'h0) begin miscompares++; $display("FAIL prio_cleanup: got %h want %h", ifc.in_service_o, 32'h0); end
   endtask

   task automatic test_backpressure();
      set_prio(3, 8'd50); set_prio(30, 8'd200);
      ifc.req_i = 32'h0000_0008;
      step();
      ifc.req_i = '0;
      step();
      for (int i = 0; i < 10; i++) begin
         if (i == 2) begin
            ifc.req_i = 32'h4000_0000;
            ifc.threshold_i = 8'd100;
         end else begin
            ifc.req_i = '0;
         end
         step();
         vectors++;
         if (offer() !== {1'b1, 5'd3, 8'd50}) begin miscompares++; $display("FAIL bp_hold[%0d]: got %h want %h", i, offer(), {1'b1, 5'd3, 8'd50}); end
      end
      vectors++;
      if (ifc.pending_o !== 32'h4000_0008) begin miscompares++; $display("FAIL bp_pending: got %h want %h", ifc.pending_o, 32'h4000_0008); end
      ifc.claim_ready_i = 1'b1;
      step();
      vectors++;
      if ({ifc.claim_valid_o, ifc.in_service_o} !== {1'b0, 32'h0000_0008}) begin miscompares++; $display("FAIL bp_handshake: got %h want %h", {ifc.claim_valid_o, ifc.in_service_o}, {1'b0, 32'h0000_0008}); end
      step();
      vectors++;
      if (offer() !== {1'b1, 5'd30, 8'd200}) begin miscompares++; $display("FAIL bp_next: got %h want %h", offer(), {1'b1, 5'd30, 8'd200}); end
      step();
      ifc.claim_ready_i = 1'b0;
      ifc.threshold_i = 8'd0;
      ifc.complete_valid_i = 1'b1; ifc.complete_idx_i = 5'd3;
      step();
      ifc.complete_idx_i = 5'd30;
      step();
      ifc.complete_valid_i = 1'b0;
      vectors++;
      if (ifc.in_service_o !== 32'h0) begin miscompares++; $display("FAIL bp_cleanup: got %h want %h", ifc.in_service_o, 32'h0); end
   endtask

   task automatic test_threshold_mask();
      ifc.threshold_i = 8'd5;
      set_prio(1, 8'd5); set_prio(4, 8'd6);
      ifc.req_i = 32'h0000_0012;
      step();
      ifc.req_i = '0;
      step();
      vectors++;
      if (offer() !== {1'b1, 5'd4, 8'd6}) begin miscompares++; $display("FAIL thr_offer: got %h want %h", offer(), {1'b1, 5'd4, 8'd6}); end
      ifc.claim_ready_i = 1'b1;
      step();
      ifc.claim_ready_i = 1'b0;
      step();
      step();
      vectors++;
      if ({ifc.claim_valid_o, ifc.pending_o, ifc.in_service_o} !== {1'b0, 32'h0000_0002, 32'h0000_0010}) begin miscompares++; $display("FAIL thr_equal_not_offered: got %h want %h", {ifc.claim_valid_o, ifc.pending_o, ifc.in_service_o}, {1'b0, 32'h0000_0002, 32'h0000_0010}); end
      ifc.req_i = 32'h0000_0010;
      step();
      ifc.req_i = '0;
      vectors++;
      if (ifc.pending_o !== 32'h0000_0002) begin miscompares++; $display("FAIL mask_req_dropped: got %h want %h", ifc.pending_o, 32'h0000_0002); end
      // request coincides with completion: still dropped
      ifc.req_i = 32'h0000_0010;
      ifc.complete_valid_i = 1'b1; ifc.complete_idx_i = 5'd4;
      step();
      ifc.req_i = '0;
      ifc.complete_valid_i = 1'b0;
      vectors++;
      if ({ifc.pending_o, ifc.in_service_o} !== {32'h0000_0002, 32'h0}) begin miscompares++; $display("FAIL mask_complete_cycle: got %h want %h", {ifc.pending_o, ifc.in_service_o}, {32'h0000_0002, 32'h0}); end
      ifc.req_i = 32'h0000_0010;
      step();
      ifc.req_i = '0;
      step();
      vectors++;
      if (offer() !== {1'b1, 5'd4, 8'd6}) begin miscompares++; $display("FAIL mask_reoffer: got %h want %h", offer(), {1'b1, 5'd4, 8'd6}); end
      ifc.claim_ready_i = 1'b1;
      step();
      ifc.claim_ready_i = 1'b0;
      ifc.complete_valid_i = 1'b1; ifc.complete_idx_i = 5'd4;
      step();
      ifc.complete_valid_i = 1'b0;
      vectors++;
      if ({ifc.pending_o, ifc.in_service_o} !== {32'h0000_0002, 32'h0}) begin miscompares++; $display("FAIL mask_cleanup: got %h want %h", {ifc.pending_o, ifc.in_service_o}, {32'h0000_0002, 32'h0}); end
   endtask

   task automatic test_corner();
      ifc.complete_valid_i = 1'b1; ifc.complete_idx_i = 5'd7;
      step();
      ifc.complete_valid_i = 1'b0;
      vectors++;
      if ({ifc.claim_valid_o, ifc.pending_o, ifc.in_service_o} !== {1'b0, 32'h0000_0002, 32'h0}) begin miscompares++; $display("FAIL corner_complete_idle: got %h want %h", {ifc.claim_valid_o, ifc.pending_o, ifc.in_service_o}, {1'b0, 32'h0000_0002, 32'h0}); end
      // five-source instance: source 0 at prio == threshold, others prio 0
      ifc5.threshold_i = 8'd4;
      ifc5.prio_i = 40'h00_0000_0004;
      ifc5.req_i = 5'b11111;
      step();
      ifc5.req_i = '0;
      step();
      step();
      vectors++;
      if ({ifc5.claim_valid_o, ifc5.pending_o} !== {1'b0, 5'b11111}) begin miscompares++; $display("FAIL n5_all_invalid: got %h want %h", {ifc5.claim_valid_o, ifc5.pending_o}, {1'b0, 5'b11111}); end
      ifc5.complete_valid_i = 1'b1; ifc5.complete_idx_i = 3'd6;
      step();
      ifc5.complete_valid_i = 1'b0;
      vectors++;
      if ({ifc5.claim_valid_o, ifc5.pending_o, ifc5.in_service_o} !== {1'b0, 5'b11111, 5'b00000}) begin miscompares++; $display("FAIL n5_complete_oob: got %h want %h", {ifc5.claim_valid_o, ifc5.pending_o, ifc5.in_service_o}, {1'b0, 5'b11111, 5'b00000}); end
      ifc5.threshold_i = 8'd3;
      step();
      vectors++;
      if (offer5() !== {1'b1, 3'd0, 8'd4}) begin miscompares++; $display("FAIL n5_offer: got %h want %h", offer5(), {1'b1, 3'd0, 8'd4}); end
      ifc5.claim_ready_i = 1'b1;
      step();
      ifc5.claim_ready_i = 1'b0;
      vectors++;
      if ({ifc5.pending_o, ifc5.in_service_o} !== {5'b11110, 5'b00001}) begin miscompares++; $display("FAIL n5_claimed: got %h want %h", {ifc5.pending_o, ifc5.in_service_o}, {5'b11110, 5'b00001}); end
   endtask

   task automatic test_reset_mid_offer();
      ifc.threshold_i = 8'd0;
      set_prio(7, 8'd9);
      ifc.req_i = 32'h0000_0080;
      step();
      ifc.req_i = '0;
      vectors++;
      if (offer() !== {1'b1, 5'd1, 8'd5}) begin miscompares++; $display("FAIL rst_pre_offer1: got %h want %h", offer(), {1'b1, 5'd1, 8'd5}); end
      ifc.claim_ready_i = 1'b1;
      step();
      ifc.claim_ready_i = 1'b0;
      step();
      vectors++;
      if ({offer(), ifc.pending_o, ifc.in_service_o} !== {1'b1, 5'd7, 8'd9, 32'h0000_0080, 32'h0000_0002}) begin miscompares++; $display("FAIL rst_pre_offer7: got %h want %h", {offer(), ifc.pending_o, ifc.in_service_o}, {1'b1, 5'd7, 8'd9, 32'h0000_0080, 32'h0000_0002}); end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({offer(), ifc.pending_o, ifc.in_service_o} !== {14'h0, 32'h0, 32'h0}) begin miscompares++; $display("FAIL rst_async_clear: got %h want %h", {offer(), ifc.pending_o, ifc.in_service_o}, {14'h0, 32'h0, 32'h0}); end
      vectors++;
      if ({ifc5.pending_o, ifc5.in_service_o} !== 10'h0) begin miscompares++; $display("FAIL rst_async_clear5: got %h want %h", {ifc5.pending_o, ifc5.in_service_o}, 10'h0); end
      step();
      step();
      rst_n = 1'b1;
      set_prio(12, 8'd40);
      ifc.req_i = 32'h0000_1000;
      step();
      ifc.req_i = '0;
      step();
      vectors++;
      if (offer() !== {1'b1, 5'd12, 8'd40}) begin miscompares++; $display("FAIL rst_after_offer: got %h want %h", offer(), {1'b1, 5'd12, 8'd40}); end
      ifc.claim_ready_i = 1'b1;
      step();
      ifc.claim_ready_i = 1'b0;
      vectors++;
      if ({ifc.claim_valid_o, ifc.pending_o, ifc.in_service_o} !== {1'b0, 32'h0, 32'h0000_1000}) begin miscompares++; $display("FAIL rst_after_claim: got %h want %h", {ifc.claim_valid_o, ifc.pending_o, ifc.in_service_o}, {1'b0, 32'h0, 32'h0000_1000}); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_single();
      test_priority();
      test_backpressure();
      test_threshold_mask();
      test_corner();
      test_reset_mid_offer();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
